// File: rtl/day_phase_timer_if.sv
// Time-load handshake bundle for day_phase_timer: valid/ready transfer plus the reject pulse.
interface day_phase_timer_if;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       set_ready;
    logic       set_err;

    modport master (output set_valid, set_hour, set_min, input set_ready, set_err);
    modport slave  (input set_valid, set_hour, set_min, output set_ready, set_err);
endinterface

// File: rtl/day_phase_timer.sv
// Hour:minute clock with one-hot day-phase code for the lighting controller.
// Optional build macro DAY_PHASE_FAST_SIM_EN: every tick_en advances the minute (no prescaler).
module day_phase_timer #(
    parameter int unsigned TICKS_PER_MIN = 60,
    parameter int unsigned MORNING_H     = 6,
    parameter int unsigned AFTERNOON_H   = 12,
    parameter int unsigned EVENING_H     = 18,
    parameter int unsigned NIGHT_H       = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_en,
    day_phase_timer_if.slave    set_if,
    output logic [4:0]          hour,
    output logic [5:0]          minute,
    output logic [3:0]          tcode,
    output logic                tcode_valid,
    output logic                phase_chg
);
    localparam logic [4:0] MORN_H  = 5'(MORNING_H);
    localparam logic [4:0] AFTN_H  = 5'(AFTERNOON_H);
    localparam logic [4:0] EVEN_H  = 5'(EVENING_H);
    localparam logic [4:0] NITE_H  = 5'(NIGHT_H);
    localparam logic [7:0] PSC_MAX = 8'(TICKS_PER_MIN - 1);

    typedef enum logic [1:0] {UNSET, RUN, LOAD} state_t;

    state_t     state, state_nxt;
    logic [7:0] presc, presc_nxt;
    logic [4:0] hour_nxt;
    logic [5:0] min_nxt;
    logic [3:0] tcode_nxt;
    logic       tvld_nxt, err_nxt, accept, legal, min_step;

    function automatic logic [3:0] phase_of(input logic [4:0] h);
        if (h >= MORN_H && h < AFTN_H) return 4'b0001;
        if (h >= AFTN_H && h < EVEN_H) return 4'b0010;
        if (h >= EVEN_H && h < NITE_H) return 4'b0100;
        return 4'b1000;
    endfunction

    assign set_if.set_ready = (state != LOAD);
    assign accept = set_if.set_valid && set_if.set_ready;
    assign legal  = (set_if.set_hour <= 5'd23) && (set_if.set_min <= 6'd59);

    always_comb begin
        state_nxt = state;
        hour_nxt  = hour;
        min_nxt   = minute;
        presc_nxt = presc;
        tvld_nxt  = tcode_valid;
        err_nxt   = 1'b0;
        min_step  = 1'b0;

        if (state != UNSET && tick_en) begin
`ifdef DAY_PHASE_FAST_SIM_EN
            min_step = 1'b1;
`else
            if (presc == PSC_MAX) begin
                presc_nxt = 8'd0;
                min_step  = 1'b1;
            end else begin
                presc_nxt = presc + 8'd1;
            end
`endif
        end

        if (min_step) begin
            if (minute == 6'd59) begin
                min_nxt  = 6'd0;
                hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
                min_nxt = minute + 6'd1;
            end
        end

        if (state == LOAD) state_nxt = RUN;

        // A legal load overrides any tick/rollover computed above on the same edge.
        if (accept) begin
            if (legal) begin
                hour_nxt  = set_if.set_hour;
                min_nxt   = set_if.set_min;
                presc_nxt = 8'd0;
                tvld_nxt  = 1'b1;
                state_nxt = LOAD;
            end else begin
                err_nxt = 1'b1;
            end
        end

        tcode_nxt = tvld_nxt ? phase_of(hour_nxt) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNSET;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour           <= 5'd0;
            minute         <= 6'd0;
            presc          <= 8'd0;
            tcode          <= 4'b0000;
            tcode_valid    <= 1'b0;
            set_if.set_err <= 1'b0;
            phase_chg      <= 1'b0;
        end else begin
            hour           <= hour_nxt;
            minute         <= min_nxt;
            presc          <= presc_nxt;
            tcode          <= tcode_nxt;
            tcode_valid    <= tvld_nxt;
            set_if.set_err <= err_nxt;
            phase_chg      <= (tcode_nxt != tcode);
        end
    end
endmodule

// File: tb/tb_day_phase_timer.sv
// Directed self-checking bench for day_phase_timer (TICKS_PER_MIN=4; one tick per minute in the fast build).
module tb_day_phase_timer;
`ifdef DAY_PHASE_FAST_SIM_EN
    localparam int TPM = 1;
`else
    localparam int TPM = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [3:0] tcode;
    logic       tcode_valid, phase_chg;
    logic       pc_seen;
    int         n_cmp = 0;
    int         n_bad = 0;

    day_phase_timer_if sif();

    day_phase_timer #(.TICKS_PER_MIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .set_if(sif),
        .hour(hour), .minute(minute), .tcode(tcode),
        .tcode_valid(tcode_valid), .phase_chg(phase_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_en = 1'b1;
            step();
            pc_seen |= phase_chg;
        end
        tick_en = 1'b0;
    endtask

    task automatic load(input logic [4:0] h, input logic [5:0] m);
        sif.set_valid = 1'b1;
        sif.set_hour  = h;
        sif.set_min   = m;
        step();
        sif.set_valid = 1'b0;
    endtask

    task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m, input logic [3:0] tc);
        chk({tag, ".hour"},  32'(hour),   32'(h));
        chk({tag, ".min"},   32'(minute), 32'(m));
        chk({tag, ".tcode"}, 32'(tcode),  32'(tc));
    endtask

    initial begin
        sif.set_valid = 1'b0;
        sif.set_hour  = 5'd0;
        sif.set_min   = 6'd0;
        #12 rst_n = 1'b1;
        step();
        chk_time("rst", 5'd0, 6'd0, 4'b0000);
        chk("rst.tvld",  32'(tcode_valid),   32'd0);
        chk("rst.ready", 32'(sif.set_ready), 32'd1);
        chk("rst.err",   32'(sif.set_err),   32'd0);
        chk("rst.pchg",  32'(phase_chg),     32'd0);

        // ticks while unset are ignored
        pc_seen = 1'b0;
        tick(10);
        chk_time("unset", 5'd0, 6'd0, 4'b0000);
        chk("unset.tvld", 32'(tcode_valid), 32'd0);
        chk("unset.pchg", 32'(pc_seen),     32'd0);

        // first load: 05:59 is night
        load(5'd5, 6'd59);
        chk_time("ld0559", 5'd5, 6'd59, 4'b1000);
        chk("ld0559.tvld",  32'(tcode_valid),   32'd1);
        chk("ld0559.pchg",  32'(phase_chg),     32'd1);
        chk("ld0559.ready", 32'(sif.set_ready), 32'd0);
        step();
        chk("ld0559.ready2", 32'(sif.set_ready), 32'd1);
        chk("ld0559.pchg2",  32'(phase_chg),     32'd0);
        tick(TPM - 1);
        chk("pre0600.min", 32'(minute), 32'd59);
        tick(1);
        chk_time("t0600", 5'd6, 6'd0, 4'b0001);
        chk("t0600.pchg", 32'(phase_chg), 32'd1);
        step();
        chk("t0600.pchg2", 32'(phase_chg), 32'd0);

        // midnight wrap stays in night phase
        load(5'd23, 6'd59);
        chk("ld2359.pchg", 32'(phase_chg), 32'd1);
        step();
        pc_seen = 1'b0;
        tick(TPM);
        chk_time("t0000", 5'd0, 6'd0, 4'b1000);
        chk("t0000.pchg", 32'(pc_seen), 32'd0);

        // out-of-range loads rejected
        load(5'd24, 6'd10);
        chk("bad24.err",   32'(sif.set_err),   32'd1);
        chk("bad24.ready", 32'(sif.set_ready), 32'd1);
        chk_time("bad24", 5'd0, 6'd0, 4'b1000);
        step();
        chk("bad24.err2", 32'(sif.set_err), 32'd0);
        load(5'd7, 6'd60);
        chk("bad60.err",   32'(sif.set_err),   32'd1);
        chk("bad60.ready", 32'(sif.set_ready), 32'd1);
        chk_time("bad60", 5'd0, 6'd0, 4'b1000);
        step();
        chk("bad60.err2", 32'(sif.set_err), 32'd0);

        // load collides with the 11:59 -> 12:00 rollover tick: load wins
        load(5'd11, 6'd59);
        step();
        tick(TPM - 1);
        chk("pre1200.min", 32'(minute), 32'd59);
        tick_en = 1'b1;
        load(5'd17, 6'd30);
        tick_en = 1'b0;
        chk_time("coll", 5'd17, 6'd30, 4'b0010);
        chk("coll.pchg", 32'(phase_chg), 32'd1);
        tick(TPM - 1);
        chk("coll.psc0", 32'(minute), 32'd30);
        tick(1);
        chk("coll.psc1", 32'(minute), 32'd31);

        // 11:58 + 2 minutes enters afternoon
        load(5'd11, 6'd58);
        chk("ld1158.tcode", 32'(tcode), 32'(4'b0001));
        step();
        tick(2 * TPM);
        chk_time("t1200", 5'd12, 6'd0, 4'b0010);
        chk("t1200.pchg", 32'(phase_chg), 32'd1);

        // async reset between edges
        load(5'd21, 6'd15);
        step();
        tick(3);
        chk("pre_rst.tcode", 32'(tcode), 32'(4'b0100));
        #2 rst_n = 1'b0;
        #1;
        chk_time("arst", 5'd0, 6'd0, 4'b0000);
        chk("arst.tvld",  32'(tcode_valid),   32'd0);
        chk("arst.ready", 32'(sif.set_ready), 32'd1);
        chk("arst.pchg",  32'(phase_chg),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tick(2 * TPM);
        chk_time("post_rst", 5'd0, 6'd0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
